// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory request/response, downstream redirect,
// and the decoder-facing instruction handshake.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_rsp_valid;
  logic [31:0]       imem_rsp_data;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [31:0]       inst;
  logic [ADDR_W-1:0] inst_pc;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding word fetch, small in-order
// instruction buffer toward the decoder, redirect flush with late-response drop.
module fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              outstanding_q, outstanding_d;
  logic              drop_q, drop_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
  logic [ADDR_W-1:0] pc_mem_d   [DEPTH];
  logic [31:0]       data_mem_q [DEPTH];
  logic [31:0]       data_mem_d [DEPTH];

  logic              req_valid, req_fire, rsp_fire, head_valid, push, pop;
  logic [ADDR_W-1:0] redirect_target;

  always_comb begin
    // Issue depends only on registered state; count + outstanding < DEPTH
    // reduces to count < DEPTH because outstanding must already be clear.
    req_valid       = !reset && !outstanding_q && (count_q < FULL);
    req_fire        = req_valid && bus.imem_req_ready;
    rsp_fire        = bus.imem_rsp_valid && outstanding_q;
    head_valid      = !reset && (count_q != '0);
    pop             = head_valid && bus.inst_ready;
    push            = rsp_fire && !drop_q && !bus.redirect_valid;
    redirect_target = bus.redirect_pc & ~ADDR_W'(3);

    fetch_pc_d    = fetch_pc_q;
    req_addr_d    = req_addr_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    pc_mem_d      = pc_mem_q;
    data_mem_d    = data_mem_q;

    if (req_fire) begin
      fetch_pc_d    = fetch_pc_q + ADDR_W'(4);
      req_addr_d    = fetch_pc_q;
      outstanding_d = 1'b1;
    end

    if (rsp_fire) begin
      outstanding_d = 1'b0;
      drop_d        = 1'b0;
    end

    if (push) begin
      pc_mem_d[wr_ptr_q]   = req_addr_q;
      data_mem_d[wr_ptr_q] = bus.imem_rsp_data;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Redirect overrides the sequential PC and empties the buffer; any response
    // still in flight (including one issued this cycle) belongs to the old path.
    if (bus.redirect_valid) begin
      fetch_pc_d = redirect_target;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      if (req_fire || (outstanding_q && !bus.imem_rsp_valid)) begin
        drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      req_addr_q    <= RESET_PC;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      req_addr_q    <= req_addr_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    pc_mem_q   <= pc_mem_d;
    data_mem_q <= data_mem_d;
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.inst_valid     = head_valid;
  assign bus.inst           = data_mem_q[rd_ptr_q];
  assign bus.inst_pc        = pc_mem_q[rd_ptr_q];
endmodule
